// File: rtl/muldiv_sequencer_pkg.sv
// rtl/muldiv_sequencer_pkg.sv - shared MULDIV mode encodings, HI/LO select constants and helpers
package muldiv_sequencer_pkg;

  typedef enum logic [3:0] {
    MULDIV_NOTHING = 4'd0,
    MULDIV_MULT    = 4'd1,
    MULDIV_MULTU   = 4'd2,
    MULDIV_DIV     = 4'd3,
    MULDIV_DIVU    = 4'd4,
    MULDIV_MTHI    = 4'd5,
    MULDIV_MTLO    = 4'd6
  } muldiv_mode_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } muldiv_state_e;

  localparam logic MULDIV_HIGH = 1'b1;
  localparam logic MULDIV_LOW  = 1'b0;

  localparam int MULT_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF  = 10;

  // Modes that produce a 64-bit result and occupy the unit for a fixed latency
  function automatic logic is_arith(input muldiv_mode_e m);
    return (m == MULDIV_MULT) || (m == MULDIV_MULTU) ||
           (m == MULDIV_DIV)  || (m == MULDIV_DIVU);
  endfunction

  function automatic logic is_divide(input muldiv_mode_e m);
    return (m == MULDIV_DIV) || (m == MULDIV_DIVU);
  endfunction

endpackage

// File: rtl/muldiv_core.sv
// rtl/muldiv_core.sv - combinational 64-bit {HI,LO} result for mult/multu/div/divu
module muldiv_core
  import muldiv_sequencer_pkg::*;
(
  input  logic [3:0]  i_mode,
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  output logic [63:0] o_result
);

  muldiv_mode_e w_mode;
  logic [63:0]  w_prod_s;
  logic [63:0]  w_prod_u;
  logic         w_signed;
  logic         w_neg_a;
  logic         w_neg_b;
  logic [31:0]  w_abs_a;
  logic [31:0]  w_abs_b;
  logic [31:0]  w_div_b;
  logic [31:0]  w_quo_mag;
  logic [31:0]  w_rem_mag;
  logic [31:0]  w_quo;
  logic [31:0]  w_rem;
  logic         w_div_zero;

  assign w_mode   = muldiv_mode_e'(i_mode);
  assign w_prod_s = $signed({{32{i_a[31]}}, i_a}) * $signed({{32{i_b[31]}}, i_b});
  assign w_prod_u = {32'd0, i_a} * {32'd0, i_b};

  // Signed divide runs on magnitudes; 0x8000_0000 / -1 falls out as LO=0x8000_0000, HI=0
  assign w_signed   = (w_mode == MULDIV_DIV);
  assign w_neg_a    = w_signed & i_a[31];
  assign w_neg_b    = w_signed & i_b[31];
  assign w_abs_a    = w_neg_a ? (32'd0 - i_a) : i_a;
  assign w_abs_b    = w_neg_b ? (32'd0 - i_b) : i_b;
  assign w_div_zero = (i_b == 32'd0);
  assign w_div_b    = w_div_zero ? 32'd1 : w_abs_b;
  assign w_quo_mag  = w_abs_a / w_div_b;
  assign w_rem_mag  = w_abs_a % w_div_b;
  assign w_quo      = (w_neg_a ^ w_neg_b) ? (32'd0 - w_quo_mag) : w_quo_mag;
  assign w_rem      = w_neg_a ? (32'd0 - w_rem_mag) : w_rem_mag;

  always_comb begin
    o_result = 64'd0;
    case (w_mode)
      MULDIV_MULT:  o_result = w_prod_s;
      MULDIV_MULTU: o_result = w_prod_u;
      MULDIV_DIV,
      MULDIV_DIVU: begin
        if (w_div_zero) o_result = {i_a, 32'hFFFF_FFFF};
        else            o_result = {w_rem, w_quo};
      end
      default:      o_result = 64'd0;
    endcase
  end

endmodule

// File: rtl/muldiv_sequencer.sv
// rtl/muldiv_sequencer.sv - EX-stage HI/LO sequencer: fixed-latency mult/div, mthi/mtlo, HI/LO reads
module muldiv_sequencer
  import muldiv_sequencer_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_start,
  input  logic [3:0]  i_muldiv_mode,
  input  logic        i_flush,
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  input  logic        i_hilo_sel,
  output logic        o_busy,
  output logic [31:0] o_rdata,
  output logic [31:0] o_hi,
  output logic [31:0] o_lo
);

  localparam int CNT_W = $clog2(DIV_CYCLES + 1);
  localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES);
  localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  muldiv_state_e    r_state;
  muldiv_state_e    w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [31:0]      r_phi;
  logic [31:0]      r_plo;
  logic [31:0]      r_hi;
  logic [31:0]      r_lo;
  logic [31:0]      w_phi_nxt;
  logic [31:0]      w_plo_nxt;
  logic [31:0]      w_hi_nxt;
  logic [31:0]      w_lo_nxt;
  muldiv_mode_e     w_mode;
  logic             w_accept;
  logic [63:0]      w_result;

  assign w_mode   = muldiv_mode_e'(i_muldiv_mode);
  assign w_accept = i_start & ~i_flush & (r_state == ST_IDLE) & (w_mode != MULDIV_NOTHING);

  muldiv_core u_core (
    .i_mode   (i_muldiv_mode),
    .i_a      (i_a),
    .i_b      (i_b),
    .o_result (w_result)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_phi_nxt   = r_phi;
    w_plo_nxt   = r_plo;
    w_hi_nxt    = r_hi;
    w_lo_nxt    = r_lo;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          if (is_arith(w_mode)) begin
            w_phi_nxt   = w_result[63:32];
            w_plo_nxt   = w_result[31:0];
            w_cnt_nxt   = is_divide(w_mode) ? DIV_LOAD : MULT_LOAD;
            w_state_nxt = ST_BUSY;
          end else if (w_mode == MULDIV_MTHI) begin
            w_hi_nxt = i_a;
          end else if (w_mode == MULDIV_MTLO) begin
            w_lo_nxt = i_a;
          end
        end
      end
      ST_BUSY: begin
        // Flush is deliberately ignored here: the in-flight op is already committed
        w_cnt_nxt = r_cnt - CNT_ONE;
        if (r_cnt == CNT_ONE) begin
          w_hi_nxt    = r_phi;
          w_lo_nxt    = r_plo;
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_phi   <= 32'd0;
      r_plo   <= 32'd0;
      r_hi    <= 32'd0;
      r_lo    <= 32'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_phi   <= w_phi_nxt;
      r_plo   <= w_plo_nxt;
      r_hi    <= w_hi_nxt;
      r_lo    <= w_lo_nxt;
    end
  end

  assign o_busy  = (r_state == ST_BUSY);
  assign o_hi    = r_hi;
  assign o_lo    = r_lo;
  assign o_rdata = (i_hilo_sel == MULDIV_HIGH) ? r_hi : r_lo;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// tb/tb_muldiv_sequencer.sv - self-checking bench for muldiv_sequencer
module tb_muldiv_sequencer;

  localparam int MC = 5;
  localparam int DC = 10;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [3:0]  mode;
  logic        flush;
  logic [31:0] a;
  logic [31:0] b;
  logic        hilo_sel;
  logic        busy;
  logic [31:0] rdata;
  logic [31:0] hi;
  logic [31:0] lo;

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  logic [31:0] m_hi, m_lo, m_phi, m_plo;
  int          m_left;

  always #5 clk = ~clk;

  muldiv_sequencer #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .i_clk         (clk),
    .i_reset       (reset),
    .i_start       (start),
    .i_muldiv_mode (mode),
    .i_flush       (flush),
    .i_a           (a),
    .i_b           (b),
    .i_hilo_sel    (hilo_sel),
    .o_busy        (busy),
    .o_rdata       (rdata),
    .o_hi          (hi),
    .o_lo          (lo)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] ref_result(input int md, input logic [31:0] x, input logic [31:0] y);
    longint      sx, sy, q, r;
    logic [63:0] ux, uy, res;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    ux = {32'd0, x};
    uy = {32'd0, y};
    res = 64'd0;
    case (md)
      1: res = sx * sy;
      2: res = ux * uy;
      3: begin
        if (y == 0) res = {x, 32'hFFFF_FFFF};
        else begin
          q = sx / sy;
          r = sx % sy;
          res = {r[31:0], q[31:0]};
        end
      end
      4: begin
        if (y == 0) res = {x, 32'hFFFF_FFFF};
        else begin
          q = longint'(ux / uy);
          r = longint'(ux % uy);
          res = {r[31:0], q[31:0]};
        end
      end
      default: res = 64'd0;
    endcase
    return res;
  endfunction

  // Operation-level model: remaining busy cycles plus committed/pending HI/LO
  always @(posedge clk) begin
    if (reset) begin
      m_hi = 0; m_lo = 0; m_phi = 0; m_plo = 0; m_left = 0;
    end else if (m_left > 0) begin
      m_left--;
      if (m_left == 0) begin
        m_hi = m_phi;
        m_lo = m_plo;
      end
    end else if (start && !flush) begin
      case (int'(mode))
        1, 2, 3, 4: begin
          {m_phi, m_plo} = ref_result(int'(mode), a, b);
          m_left = (mode >= 3) ? DC : MC;
        end
        5: m_hi = a;
        6: m_lo = a;
        default: ;
      endcase
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("busy", {31'd0, busy}, {31'd0, (m_left > 0)});
      chk("hi", hi, m_hi);
      chk("lo", lo, m_lo);
      chk("rdata", rdata, hilo_sel ? m_hi : m_lo);
    end
  end

  // Called at posedge+1; holds the request for exactly one cycle
  task automatic issue(input logic [3:0] md, input logic [31:0] x, input logic [31:0] y, input logic fl);
    start = 1'b1; mode = md; a = x; b = y; flush = fl;
    @(posedge clk); #1;
    start = 1'b0; mode = 4'd0; flush = 1'b0;
  endtask

  task automatic count_busy(output int n);
    n = 0;
    while (busy && n < 50) begin
      n++;
      @(posedge clk); #1;
    end
    if (n >= 50) chk("busy_timeout", 32'(n), 32'd0);
  endtask

  int n;

  initial begin
    reset = 1'b1; start = 1'b0; mode = 4'd0; flush = 1'b0;
    a = 0; b = 0; hilo_sel = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    chk_en = 1'b1;
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_hi", hi, 32'd0);
    chk("reset_lo", lo, 32'd0);

    issue(4'd1, 32'hFFFF_FFFD, 32'd7, 1'b0);
    count_busy(n);
    chk("mult_cycles", 32'(n), 32'd5);
    chk("mult_hi", hi, 32'hFFFF_FFFF);
    chk("mult_lo", lo, 32'hFFFF_FFEB);

    issue(4'd2, 32'hFFFF_FFFF, 32'd2, 1'b0);
    count_busy(n);
    chk("multu_cycles", 32'(n), 32'd5);
    chk("multu_hi", hi, 32'd1);
    chk("multu_lo", lo, 32'hFFFF_FFFE);

    issue(4'd3, 32'hFFFF_FFF9, 32'd2, 1'b0);
    count_busy(n);
    chk("div_cycles", 32'(n), 32'd10);
    chk("div_lo", lo, 32'hFFFF_FFFD);
    chk("div_hi", hi, 32'hFFFF_FFFF);

    issue(4'd4, 32'd7, 32'd0, 1'b0);
    count_busy(n);
    chk("divu0_cycles", 32'(n), 32'd10);
    chk("divu0_hi", hi, 32'd7);
    chk("divu0_lo", lo, 32'hFFFF_FFFF);

    issue(4'd1, 32'd5, 32'd5, 1'b1);
    chk("flush_busy", {31'd0, busy}, 32'd0);
    chk("flush_hi", hi, 32'd7);
    chk("flush_lo", lo, 32'hFFFF_FFFF);
    issue(4'd6, 32'h55, 32'd0, 1'b1);
    chk("flush_mtlo", lo, 32'hFFFF_FFFF);

    hilo_sel = 1'b1;
    issue(4'd5, 32'h1234, 32'd0, 1'b0);
    chk("mthi_rdata", rdata, 32'h1234);
    chk("mthi_busy", {31'd0, busy}, 32'd0);
    hilo_sel = 1'b0;
    issue(4'd6, 32'hCAFE, 32'd0, 1'b0);
    chk("mtlo_rdata", rdata, 32'hCAFE);

    issue(4'd3, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    count_busy(n);
    chk("ovf_lo", lo, 32'h8000_0000);
    chk("ovf_hi", hi, 32'd0);

    // Back-to-back: second accept in the first idle cycle
    issue(4'd3, 32'd7, 32'hFFFF_FFFE, 1'b0);
    count_busy(n);
    issue(4'd1, 32'd3, 32'd4, 1'b0);
    chk("b2b_div_lo", lo, 32'hFFFF_FFFD);
    chk("b2b_div_hi", hi, 32'd1);
    count_busy(n);
    chk("b2b_mult_cycles", 32'(n), 32'd5);
    chk("b2b_mult_lo", lo, 32'd12);

    issue(4'd3, 32'd100, 32'd7, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("rst_mid_busy", {31'd0, busy}, 32'd0);
    chk("rst_mid_hi", hi, 32'd0);
    chk("rst_mid_lo", lo, 32'd0);
    issue(4'd1, 32'd2, 32'd3, 1'b0);
    count_busy(n);
    chk("post_rst_lo", lo, 32'd6);
    chk("post_rst_hi", hi, 32'd0);

    repeat (2) @(posedge clk);
    #1 chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
